cp0_exception_unit: RTL and testbench

- WB-end consumer of the exception vector carried through the pipeline registers; the responder to the stage-side exception tagging.
- Prioritises the exception of the instruction in WB, raises a full pipeline flush and redirect, and updates the CP0 registers BadVAddr, Count, Compare, Status, Cause and EPC.
- Executes ERET and MTC0/MFC0 accesses, and returns the interrupt-pending flag that decode ORs into the Interrupt bit.

---
 rtl/cp0_exception_unit.sv | 198 +++++++++++++++++++
 tb/tb_cp0_exception_unit.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cp0_exception_unit.sv
`default_nettype none
// ============================================================================
// Module      : cp0_exception_unit
// Description : WB-stage exception responder. Prioritises the exception
//               vector of the WB instruction, issues flush/redirect, runs
//               ERET and MTC0/MFC0, and maintains BadVAddr, Count, Compare,
//               Status, Cause and EPC plus the interrupt-pending flag.
// Revision    : 1.0 - initial release
// ============================================================================
module cp0_exception_unit #(
  parameter logic [31:0] EXC_VECTOR   = 32'hBFC0_0380,
  parameter logic [31:0] STATUS_RESET = 32'h0040_0000
) (
  input  logic        clk,
  input  logic        rst,               // asynchronous, active-low
  input  logic        wb_valid,
  input  logic [8:0]  wb_except,
  input  logic [31:0] wb_pc,
  input  logic        wb_in_delay_slot,
  input  logic [31:0] wb_alu_out,
  input  logic        cp0_wr,
  input  logic [4:0]  cp0_waddr,
  input  logic [31:0] cp0_wdata,
  input  logic [4:0]  cp0_raddr,
  output logic [31:0] cp0_rdata,
  input  logic [5:0]  ext_int,
  output logic        flush_all,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        int_pending,
  output logic [31:0] epc_out
);

  // CP0 register numbers
  localparam logic [4:0] C_BADVADDR = 5'd8;
  localparam logic [4:0] C_COUNT    = 5'd9;
  localparam logic [4:0] C_COMPARE  = 5'd11;
  localparam logic [4:0] C_STATUS   = 5'd12;
  localparam logic [4:0] C_CAUSE    = 5'd13;
  localparam logic [4:0] C_EPC      = 5'd14;

  // Software-writable Status bits: IM[15:8], EXL[1], IE[0]
  localparam logic [31:0] C_STATUS_WMASK = 32'h0000_FF03;

  // Positions inside wb_except (MSB first)
  localparam int C_B_INT  = 8;
  localparam int C_B_IFA  = 7;
  localparam int C_B_RI   = 6;
  localparam int C_B_OV   = 5;
  localparam int C_B_SYS  = 4;
  localparam int C_B_BRK  = 3;
  localparam int C_B_ERET = 2;
  localparam int C_B_WRA  = 1;
  localparam int C_B_RDA  = 0;

  logic [31:0] status_q, status_d;
  logic [31:0] cause_q, cause_d;
  logic [31:0] epc_q, epc_d;
  logic [31:0] badvaddr_q, badvaddr_d;
  logic [31:0] count_q, count_d;
  logic [31:0] compare_q, compare_d;
  logic        tick_q, tick_d;

  logic        exc_take;
  logic        eret_take;
  logic [4:0]  exc_code;
  logic        badv_upd;
  logic [31:0] badv_val;
  logic        mtc0_en;

  // Exception select: highest-priority cause of the WB instruction
  always_comb begin
    exc_take  = wb_valid && ((|wb_except[8:3]) || (|wb_except[1:0]));
    eret_take = wb_valid && wb_except[C_B_ERET] && !((|wb_except[8:3]) || (|wb_except[1:0]));
    exc_code  = 5'h00;
    badv_upd  = 1'b0;
    badv_val  = wb_alu_out;
    if (wb_except[C_B_INT]) begin
      exc_code = 5'h00;
    end else if (wb_except[C_B_IFA]) begin
      exc_code = 5'h04;
      badv_upd = 1'b1;
      badv_val = wb_pc;
    end else if (wb_except[C_B_RI]) begin
      exc_code = 5'h0A;
    end else if (wb_except[C_B_OV]) begin
      exc_code = 5'h0C;
    end else if (wb_except[C_B_SYS]) begin
      exc_code = 5'h08;
    end else if (wb_except[C_B_BRK]) begin
      exc_code = 5'h09;
    end else if (wb_except[C_B_RDA]) begin
      exc_code = 5'h04;
      badv_upd = 1'b1;
    end else if (wb_except[C_B_WRA]) begin
      exc_code = 5'h05;
      badv_upd = 1'b1;
    end
  end

  // Flush/redirect for a taken exception or ERET, same cycle
  always_comb begin
    flush_all      = exc_take || eret_take;
    redirect_valid = exc_take || eret_take;
    redirect_pc    = 32'h0;
    if (exc_take) begin
      redirect_pc = EXC_VECTOR;
    end else if (eret_take) begin
      redirect_pc = epc_q;
    end
    int_pending = status_q[0] && !status_q[1] && (|(cause_q[15:8] & status_q[15:8]));
    epc_out     = epc_q;
  end

  // Next-state for all CP0 registers; exceptions suppress the MTC0 write
  always_comb begin
    status_d   = status_q;
    cause_d    = cause_q;
    epc_d      = epc_q;
    badvaddr_d = badvaddr_q;
    compare_d  = compare_q;
    tick_d     = ~tick_q;
    count_d    = tick_q ? (count_q + 32'd1) : count_q;
    mtc0_en    = cp0_wr && !exc_take;

    // Hardware pending lines; IP7 carries the timer alongside ext_int[5]
    cause_d[15:10] = {ext_int[5] | cause_q[30], ext_int[4:0]};

    if ((count_q == compare_q) && (compare_q != 32'h0)) begin
      cause_d[30] = 1'b1;
    end

    if (mtc0_en) begin
      case (cp0_waddr)
        C_COUNT:   count_d = cp0_wdata;
        C_COMPARE: begin
          compare_d   = cp0_wdata;
          cause_d[30] = 1'b0;
        end
        C_STATUS:  status_d = (status_q & ~C_STATUS_WMASK) | (cp0_wdata & C_STATUS_WMASK);
        C_CAUSE:   cause_d[9:8] = cp0_wdata[9:8];
        C_EPC:     epc_d = cp0_wdata;
        default:   ;
      endcase
    end

    if (exc_take) begin
      cause_d[6:2] = exc_code;
      // A nested exception keeps the original return point
      if (!status_q[1]) begin
        epc_d       = wb_in_delay_slot ? (wb_pc - 32'd4) : wb_pc;
        cause_d[31] = wb_in_delay_slot;
      end
      status_d[1] = 1'b1;
      if (badv_upd) begin
        badvaddr_d = badv_val;
      end
    end else if (eret_take) begin
      status_d[1] = 1'b0;
    end
  end

  // CP0 state registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      status_q   <= STATUS_RESET;
      cause_q    <= 32'h0;
      epc_q      <= 32'h0;
      badvaddr_q <= 32'h0;
      count_q    <= 32'h0;
      compare_q  <= 32'h0;
      tick_q     <= 1'b0;
    end else begin
      status_q   <= status_d;
      cause_q    <= cause_d;
      epc_q      <= epc_d;
      badvaddr_q <= badvaddr_d;
      count_q    <= count_d;
      compare_q  <= compare_d;
      tick_q     <= tick_d;
    end
  end

  // MFC0 read port, pre-edge values only
  always_comb begin
    case (cp0_raddr)
      C_BADVADDR: cp0_rdata = badvaddr_q;
      C_COUNT:    cp0_rdata = count_q;
      C_COMPARE:  cp0_rdata = compare_q;
      C_STATUS:   cp0_rdata = status_q;
      C_CAUSE:    cp0_rdata = cause_q;
      C_EPC:      cp0_rdata = epc_q;
      default:    cp0_rdata = 32'h0;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_cp0_exception_unit.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_cp0_exception_unit
// Description : Self-checking bench for cp0_exception_unit: priority table
//               plus directed sequences for EXL nesting, ERET, MTC0, timer,
//               Count wrap and asynchronous reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cp0_exception_unit;

  localparam logic [31:0] EXC_VEC = 32'hBFC0_0380;

  logic        clk;
  logic        rst;
  logic        wb_valid;
  logic [8:0]  wb_except;
  logic [31:0] wb_pc;
  logic        wb_in_delay_slot;
  logic [31:0] wb_alu_out;
  logic        cp0_wr;
  logic [4:0]  cp0_waddr;
  logic [31:0] cp0_wdata;
  logic [4:0]  cp0_raddr;
  logic [31:0] cp0_rdata;
  logic [5:0]  ext_int;
  logic        flush_all;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        int_pending;
  logic [31:0] epc_out;

  int checks = 0;
  int errors = 0;

  cp0_exception_unit #(
    .EXC_VECTOR  (32'hBFC0_0380),
    .STATUS_RESET(32'h0040_0000)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .wb_valid        (wb_valid),
    .wb_except       (wb_except),
    .wb_pc           (wb_pc),
    .wb_in_delay_slot(wb_in_delay_slot),
    .wb_alu_out      (wb_alu_out),
    .cp0_wr          (cp0_wr),
    .cp0_waddr       (cp0_waddr),
    .cp0_wdata       (cp0_wdata),
    .cp0_raddr       (cp0_raddr),
    .cp0_rdata       (cp0_rdata),
    .ext_int         (ext_int),
    .flush_all       (flush_all),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .int_pending     (int_pending),
    .epc_out         (epc_out)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        v;
    logic [8:0]  e;
    logic [31:0] pc;
    logic [31:0] alu;
    logic        flush;
    logic [4:0]  code;
    logic [31:0] badv;
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic rd(input logic [4:0] a, output logic [31:0] d);
    cp0_raddr = a;
    #1;
    d = cp0_rdata;
  endtask

  task automatic idle();
    wb_valid         = 1'b0;
    wb_except        = 9'h0;
    wb_pc            = 32'h0;
    wb_in_delay_slot = 1'b0;
    wb_alu_out       = 32'h0;
    cp0_wr           = 1'b0;
    cp0_waddr        = 5'h0;
    cp0_wdata        = 32'h0;
  endtask

  // advance one clock edge and return at the following falling edge
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic v, input logic [8:0] e, input logic [31:0] pc,
                       input logic ds, input logic [31:0] alu);
    wb_valid         = v;
    wb_except        = e;
    wb_pc            = pc;
    wb_in_delay_slot = ds;
    wb_alu_out       = alu;
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    cp0_wr    = 1'b1;
    cp0_waddr = a;
    cp0_wdata = d;
    step();
    cp0_wr    = 1'b0;
  endtask

  logic [31:0] r;

  initial begin
    // priority table, issued while EXL=1 so EPC/BD stay frozen
    tbl[0] = '{1'b1, 9'b100000001, 32'h8000_0200, 32'h0000_2000, 1'b1, 5'h00, 32'h0000_0000};
    tbl[1] = '{1'b1, 9'b011000000, 32'h8000_0204, 32'h0000_2004, 1'b1, 5'h04, 32'h8000_0204};
    tbl[2] = '{1'b1, 9'b001100000, 32'h8000_0208, 32'h0000_2008, 1'b1, 5'h0A, 32'h8000_0204};
    tbl[3] = '{1'b1, 9'b000110000, 32'h8000_020C, 32'h0000_200C, 1'b1, 5'h0C, 32'h8000_0204};
    tbl[4] = '{1'b1, 9'b000001100, 32'h8000_0210, 32'h0000_2010, 1'b1, 5'h09, 32'h8000_0204};
    tbl[5] = '{1'b1, 9'b000000011, 32'h8000_0214, 32'h0000_2015, 1'b1, 5'h04, 32'h0000_2015};
    tbl[6] = '{1'b1, 9'b000000010, 32'h8000_0218, 32'h0000_2019, 1'b1, 5'h05, 32'h0000_2019};
    tbl[7] = '{1'b0, 9'b000100000, 32'h8000_021C, 32'h0000_201C, 1'b0, 5'h05, 32'h0000_2019};
    tbl[8] = '{1'b1, 9'b000010010, 32'h8000_0220, 32'h0000_3000, 1'b1, 5'h08, 32'h0000_2019};
    tbl[9] = '{1'b0, 9'b000000100, 32'h8000_0224, 32'h0000_3004, 1'b0, 5'h08, 32'h0000_2019};

    rst = 1'b0;
    ext_int = 6'h0;
    cp0_raddr = 5'h0;
    idle();
    repeat (3) @(negedge clk);
    rst = 1'b1;

    // reset state
    chk("rst_flush", {31'h0, flush_all}, 32'h0);
    chk("rst_redir", {31'h0, redirect_valid}, 32'h0);
    chk("rst_intp", {31'h0, int_pending}, 32'h0);
    rd(5'd12, r); chk("rst_status", r, 32'h0040_0000);
    rd(5'd13, r); chk("rst_cause", r, 32'h0);
    rd(5'd14, r); chk("rst_epc", r, 32'h0);
    rd(5'd9,  r); chk("rst_count", r, 32'h0);
    rd(5'd8,  r); chk("rst_badv", r, 32'h0);
    rd(5'd3,  r); chk("rst_unmapped", r, 32'h0);

    // Overflow, not in delay slot
    drive(1'b1, 9'b000100000, 32'hBFC0_0100, 1'b0, 32'h0);
    #1;
    chk("ov_flush", {31'h0, flush_all}, 32'h1);
    chk("ov_redir", {31'h0, redirect_valid}, 32'h1);
    chk("ov_pc", redirect_pc, EXC_VEC);
    step(); idle();
    rd(5'd14, r); chk("ov_epc", r, 32'hBFC0_0100);
    chk("ov_epc_out", epc_out, 32'hBFC0_0100);
    rd(5'd13, r); chk("ov_cause", r, 32'h0000_0030);
    rd(5'd12, r); chk("ov_status", r, 32'h0040_0002);

    // ERET back to the overflow PC
    drive(1'b1, 9'b000000100, 32'h0, 1'b0, 32'h0);
    #1;
    chk("eret1_flush", {31'h0, flush_all}, 32'h1);
    chk("eret1_pc", redirect_pc, 32'hBFC0_0100);
    step(); idle();
    rd(5'd12, r); chk("eret1_status", r, 32'h0040_0000);

    // Syscall + WrWrongAddress in delay slot: Syscall wins
    drive(1'b1, 9'b000010010, 32'h8000_0008, 1'b1, 32'h0000_1003);
    #1;
    chk("sys_flush", {31'h0, flush_all}, 32'h1);
    step(); idle();
    rd(5'd13, r); chk("sys_cause", r, 32'h8000_0020);
    rd(5'd14, r); chk("sys_epc", r, 32'h8000_0004);
    rd(5'd8,  r); chk("sys_badv", r, 32'h0);

    // nested Break while EXL=1
    drive(1'b1, 9'b000001000, 32'h8000_0100, 1'b0, 32'h0);
    step(); idle();
    rd(5'd14, r); chk("brk_epc", r, 32'h8000_0004);
    rd(5'd13, r); chk("brk_cause", r, 32'h8000_0024);
    rd(5'd12, r); chk("brk_status", r, 32'h0040_0002);

    // priority table
    for (int i = 0; i < 10; i++) begin
      drive(tbl[i].v, tbl[i].e, tbl[i].pc, 1'b0, tbl[i].alu);
      #1;
      chk($sformatf("tbl%0d_flush", i), {31'h0, flush_all}, {31'h0, tbl[i].flush});
      chk($sformatf("tbl%0d_rv", i), {31'h0, redirect_valid}, {31'h0, tbl[i].flush});
      chk($sformatf("tbl%0d_pc", i), redirect_pc, tbl[i].flush ? EXC_VEC : 32'h0);
      step(); idle();
      rd(5'd13, r); chk($sformatf("tbl%0d_code", i), {27'h0, r[6:2]}, {27'h0, tbl[i].code});
      rd(5'd8, r);  chk($sformatf("tbl%0d_badv", i), r, tbl[i].badv);
      rd(5'd14, r); chk($sformatf("tbl%0d_epc", i), r, 32'h8000_0004);
    end

    // MTC0 in an exception cycle is suppressed
    drive(1'b1, 9'b000100000, 32'h8000_0300, 1'b0, 32'h0);
    mtc0(5'd11, 32'h0000_0055);
    idle();
    rd(5'd11, r); chk("sup_compare", r, 32'h0);

    // leave EXL, then a fresh Syscall at 0x8000_0040 and ERET to it
    drive(1'b1, 9'b000000100, 32'h0, 1'b0, 32'h0);
    #1; chk("eret2_pc", redirect_pc, 32'h8000_0004);
    step(); idle();
    drive(1'b1, 9'b000010000, 32'h8000_0040, 1'b0, 32'h0);
    step(); idle();
    drive(1'b1, 9'b000000100, 32'h0, 1'b0, 32'h0);
    #1;
    chk("eret3_pc", redirect_pc, 32'h8000_0040);
    chk("eret3_flush", {31'h0, flush_all}, 32'h1);
    step(); idle();
    rd(5'd12, r); chk("eret3_exl", {31'h0, r[1]}, 32'h0);

    // Status / Cause write masks
    mtc0(5'd12, 32'hFFFF_FFFF);
    rd(5'd12, r); chk("status_mask", r, 32'h0040_FF03);
    mtc0(5'd12, 32'h0000_8001);
    rd(5'd12, r); chk("status_8001", r, 32'h0040_8001);
    mtc0(5'd13, 32'hFFFF_FFFF);
    rd(5'd13, r); chk("cause_mask", r, 32'h0000_0320);
    chk("ip_masked", {31'h0, int_pending}, 32'h0);
    mtc0(5'd13, 32'h0);
    rd(5'd13, r); chk("cause_clr", r, 32'h0000_0020);

    // Count wrap: exactly one increment across two edges
    mtc0(5'd9, 32'hFFFF_FFFF);
    rd(5'd9, r); chk("cnt_load", r, 32'hFFFF_FFFF);
    step(); step();
    rd(5'd9, r); chk("cnt_wrap", r, 32'h0);

    // timer interrupt through IP7
    mtc0(5'd11, 32'd10);
    mtc0(5'd9, 32'd0);
    chk("tmr_pre", {31'h0, int_pending}, 32'h0);
    for (int i = 0; i < 60; i++) begin
      if (int_pending) break;
      step();
    end
    chk("tmr_intp", {31'h0, int_pending}, 32'h1);
    rd(5'd13, r);
    chk("tmr_ti", {31'h0, r[30]}, 32'h1);
    chk("tmr_ip7", {31'h0, r[15]}, 32'h1);
    mtc0(5'd11, 32'h0);
    rd(5'd13, r); chk("tmr_ti_clr", {31'h0, r[30]}, 32'h0);
    step();
    chk("tmr_intp_clr", {31'h0, int_pending}, 32'h0);

    // external line masked, then unmasked
    ext_int = 6'b000001;
    step(); step();
    chk("ext_masked", {31'h0, int_pending}, 32'h0);
    rd(5'd13, r); chk("ext_ip10", {31'h0, r[10]}, 32'h1);
    mtc0(5'd12, 32'h0000_0401);
    chk("ext_unmasked", {31'h0, int_pending}, 32'h1);
    ext_int = 6'b000000;
    step();
    chk("ext_drop", {31'h0, int_pending}, 32'h0);

    // asynchronous reset in the middle of an exception cycle
    drive(1'b1, 9'b000100000, 32'h0000_1234, 1'b0, 32'h0);
    #3;
    rst = 1'b0;
    rd(5'd12, r); chk("arst_status", r, 32'h0040_0000);
    rd(5'd14, r); chk("arst_epc", r, 32'h0);
    idle();
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("arst_flush", {31'h0, flush_all}, 32'h0);
    chk("arst_redir", {31'h0, redirect_valid}, 32'h0);
    step();
    chk("arst_flush2", {31'h0, flush_all}, 32'h0);
    rd(5'd13, r); chk("arst_cause", r, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
